// File: rtl/gpu_net_pkg.sv
// Shared flit layout and helpers for the GPU network transmit arbiter.
package gpu_net_pkg;
  localparam int FLIT_W    = 16;
  localparam int DEST_W    = 6;
  localparam int PAYLOAD_W = 10;
  localparam int DEST_MSB  = 15;
  localparam int DEST_LSB  = 10;

  typedef logic [FLIT_W-1:0] flit_t;

  typedef struct packed {
    logic       vld;
    logic [2:0] port;
    flit_t      data;
  } out_stage_t;

  function automatic logic [DEST_W-1:0] flit_dest(input flit_t f);
    return f[DEST_MSB:DEST_LSB];
  endfunction

  function automatic logic [PAYLOAD_W-1:0] flit_payload(input flit_t f);
    return f[PAYLOAD_W-1:0];
  endfunction
endpackage

// File: rtl/gpu_flit_fifo.sv
// Per-port flit FIFO; head is valid whenever empty_o is low.
module gpu_flit_fifo
  import gpu_net_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic  ACLK,
  input  logic  ARESETn,
  input  logic  push_i,
  input  logic  pop_i,
  input  flit_t data_i,
  output flit_t head_o,
  output logic  full_o,
  output logic  empty_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  flit_t         mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   cnt_q;

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) wr_q <= wr_q + AW'(1);
      if (pop_i)  rd_q <= rd_q + AW'(1);
      case ({push_i, pop_i})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Storage needs no reset: contents are only observed through cnt_q.
  always_ff @(posedge ACLK) begin
    if (push_i) mem_q[wr_q] <= data_i;
  end

  assign head_o  = mem_q[rd_q];
  assign full_o  = (cnt_q == FULL_CNT);
  assign empty_o = (cnt_q == '0);
endmodule

// File: rtl/gpu_net_arbiter.sv
// Round-robin arbiter sharing the NI transmit link between N_PORTS requesters,
// with a registered output stage and drop of flits to non-existent GPUs.
module gpu_net_arbiter
  import gpu_net_pkg::*;
#(
  parameter int N_PORTS    = 4,
  parameter int FIFO_DEPTH = 2,
  parameter int GPU_ID     = 6,
  parameter int NUM_GPUS   = 32
) (
  input  logic                      ACLK,
  input  logic                      ARESETn,
  input  logic                      arb_en,
  input  logic [N_PORTS-1:0]        req_valid,
  output logic [N_PORTS-1:0]        req_ready,
  input  logic [N_PORTS*FLIT_W-1:0] req_data,
  output logic [FLIT_W-1:0]         net_data_out,
  output logic                      net_valid_out,
  input  logic                      net_ready_in,
  output logic [2:0]                grant_port,
  output logic [15:0]               sent_count,
  output logic [7:0]                drop_count
);
  localparam int PW = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
  localparam logic [DEST_W:0] GPU_LIM = (DEST_W+1)'(NUM_GPUS);

  if (N_PORTS < 2 || N_PORTS > 8 || FIFO_DEPTH < 2 ||
      (FIFO_DEPTH & (FIFO_DEPTH-1)) != 0 || NUM_GPUS > 64 || GPU_ID >= NUM_GPUS) begin : g_bad_param
    $error("gpu_net_arbiter: illegal parameter set");
  end

  logic [N_PORTS-1:0]             push, pop, full, empty;
  logic [N_PORTS-1:0][FLIT_W-1:0] head;

  // Ready comes only from registered FIFO state, held low while in reset.
  assign req_ready = ~full & {N_PORTS{ARESETn}};
  assign push      = req_valid & req_ready;

  gpu_flit_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo [N_PORTS-1:0] (
    .ACLK    (ACLK),
    .ARESETn (ARESETn),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  (req_data),
    .head_o  (head),
    .full_o  (full),
    .empty_o (empty)
  );

  function automatic logic [PW-1:0] rr_pick(input logic [N_PORTS-1:0] req,
                                            input logic [PW-1:0] ptr);
    logic [PW-1:0] sel;
    logic          found;
    int            idx;
    sel   = '0;
    found = 1'b0;
    for (int i = 0; i < N_PORTS; i++) begin
      idx = (int'(ptr) + i) % N_PORTS;
      if (!found && req[idx]) begin
        found = 1'b1;
        sel   = PW'(idx);
      end
    end
    return sel;
  endfunction

  out_stage_t    os_q, os_d;
  logic [PW-1:0] rr_q, rr_d, pick;
  logic [15:0]   sent_q, sent_d;
  logic [7:0]    drop_q, drop_d;
  logic          grant, legal;

  always_comb begin
    pick   = rr_pick(~empty, rr_q);
    grant  = arb_en && (!os_q.vld || net_ready_in) && (|(~empty));
    legal  = {1'b0, flit_dest(head[pick])} < GPU_LIM;
    pop    = '0;
    os_d   = os_q;
    os_d.vld = os_q.vld && !net_ready_in;
    rr_d   = rr_q;
    drop_d = drop_q;
    sent_d = sent_q + 16'(os_q.vld && net_ready_in);
    if (grant) begin
      pop[pick] = 1'b1;
      rr_d      = (pick == PW'(N_PORTS-1)) ? '0 : pick + PW'(1);
      if (legal) begin
        os_d.vld  = 1'b1;
        os_d.port = 3'(pick);
        os_d.data = head[pick];
      end else if (drop_q != 8'hFF) begin
        // Illegal dest still spends this cycle's grant slot.
        drop_d = drop_q + 8'd1;
      end
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      os_q   <= '0;
      rr_q   <= '0;
      sent_q <= '0;
      drop_q <= '0;
    end else begin
      os_q   <= os_d;
      rr_q   <= rr_d;
      sent_q <= sent_d;
      drop_q <= drop_d;
    end
  end

  assign net_valid_out = os_q.vld;
  assign net_data_out  = os_q.data;
  assign grant_port    = os_q.port;
  assign sent_count    = sent_q;
  assign drop_count    = drop_q;
endmodule

// File: tb/tb_gpu_net_arbiter.sv
// Directed bench for gpu_net_arbiter: queue-based reference model checked every cycle
// plus hand-computed literal expectations per scenario.
module tb_gpu_net_arbiter;
  localparam int N = 4;
  localparam int DEPTH = 2;

  logic          ACLK = 1'b0;
  logic          ARESETn = 1'b1;
  logic          arb_en = 1'b1;
  logic [N-1:0]  req_valid = '0;
  logic [N-1:0]  req_ready;
  logic [N*16-1:0] req_data = '0;
  logic [15:0]   net_data_out;
  logic          net_valid_out;
  logic          net_ready_in = 1'b0;
  logic [2:0]    grant_port;
  logic [15:0]   sent_count;
  logic [7:0]    drop_count;

  gpu_net_arbiter #(.N_PORTS(N), .FIFO_DEPTH(DEPTH), .GPU_ID(6), .NUM_GPUS(32)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn), .arb_en(arb_en),
    .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
    .net_data_out(net_data_out), .net_valid_out(net_valid_out), .net_ready_in(net_ready_in),
    .grant_port(grant_port), .sent_count(sent_count), .drop_count(drop_count)
  );

  always #5 ACLK = ~ACLK;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: per-port queues, one output slot, pointer and counters.
  logic [15:0] mq [N][$];
  logic        m_vld = 1'b0;
  logic [15:0] m_data = '0;
  logic [2:0]  m_port = '0;
  int          m_rr = 0;
  logic [15:0] m_sent = '0;
  logic [7:0]  m_drop = '0;

  function automatic logic [N-1:0] m_ready();
    logic [N-1:0] r;
    for (int p = 0; p < N; p++) r[p] = ARESETn && (mq[p].size() < DEPTH);
    return r;
  endfunction

  task automatic model_step();
    logic [N-1:0] rdy;
    logic [15:0]  f;
    int           g;
    if (!ARESETn) begin
      for (int p = 0; p < N; p++) mq[p].delete();
      m_vld = 1'b0; m_data = '0; m_port = '0; m_rr = 0; m_sent = '0; m_drop = '0;
    end else begin
      rdy = m_ready();
      g = -1;
      if (arb_en && (!m_vld || net_ready_in))
        for (int i = 0; i < N; i++)
          if (g < 0 && mq[(m_rr + i) % N].size() > 0) g = (m_rr + i) % N;
      if (m_vld && net_ready_in) m_sent++;
      if (g >= 0) begin
        f = mq[g].pop_front();
        m_rr = (g + 1) % N;
        if (f[15:10] < 6'd32) begin
          m_vld = 1'b1; m_data = f; m_port = 3'(g);
        end else begin
          if (m_drop != 8'hFF) m_drop++;
          m_vld = m_vld && !net_ready_in;
        end
      end else begin
        m_vld = m_vld && !net_ready_in;
      end
      for (int p = 0; p < N; p++)
        if (req_valid[p] && rdy[p]) mq[p].push_back(req_data[16*p +: 16]);
    end
  endtask

  always @(posedge ACLK or negedge ARESETn) model_step();

  always @(negedge ACLK) begin
    chk("valid", net_valid_out, m_vld);
    chk("data", net_data_out, m_data);
    chk("port", grant_port, m_port);
    chk("sent", sent_count, m_sent);
    chk("drop", drop_count, m_drop);
    chk("ready", req_ready, m_ready());
  end

  // Log of flits the NI is about to accept, taken after inputs settle.
  logic [15:0] log_d[$];
  logic [2:0]  log_p[$];
  always begin
    @(negedge ACLK);
    #2;
    if (ARESETn && net_valid_out && net_ready_in) begin
      log_d.push_back(net_data_out);
      log_p.push_back(grant_port);
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin @(negedge ACLK); #1; end
  endtask

  task automatic push(input int p, input logic [15:0] f);
    req_valid[p] = 1'b1;
    req_data[16*p +: 16] = f;
    cyc(1);
    req_valid[p] = 1'b0;
  endtask

  task automatic push_hold(input int p, input logic [15:0] f);
    int b;
    b = 0;
    req_valid[p] = 1'b1;
    req_data[16*p +: 16] = f;
    while (!req_ready[p] && b < 40) begin cyc(1); b++; end
    chk("push_hold_ready", req_ready[p], 1);
    cyc(1);
    req_valid[p] = 1'b0;
  endtask

  task automatic chk_entry(input string nm, input int i, input logic [15:0] d, input logic [2:0] p);
    if (i < log_d.size()) begin
      chk({nm, "_data"}, log_d[i], d);
      chk({nm, "_port"}, log_p[i], p);
    end
  endtask

  task automatic do_reset();
    ARESETn = 1'b0;
    cyc(2);
    ARESETn = 1'b1;
  endtask

  initial begin
    #1 ARESETn = 1'b0;
    cyc(3);
    chk("rst_ready", req_ready, 4'b0000);
    chk("rst_valid", net_valid_out, 0);
    ARESETn = 1'b1;
    cyc(1);
    chk("rst_ready_out", req_ready, 4'b1111);

    // Single port, one-edge latency
    net_ready_in = 1'b1;
    push(0, 16'h1C23);
    cyc(1);
    chk("t1_valid", net_valid_out, 1);
    chk("t1_data", net_data_out, 16'h1C23);
    chk("t1_port", grant_port, 0);
    cyc(1);
    chk("t1_sent", sent_count, 1);

    // Fairness from rr_ptr=0 with every FIFO holding two flits
    do_reset();
    arb_en = 1'b0;
    for (int k = 0; k < 2; k++) begin
      req_valid = '1;
      for (int p = 0; p < N; p++) req_data[16*p +: 16] = {6'(p + 1), 10'(k * 16 + p)};
      cyc(1);
    end
    req_valid = '0;
    chk("t2_full", req_ready, 4'b0000);
    log_d.delete(); log_p.delete();
    arb_en = 1'b1;
    cyc(10);
    chk("t2_count", log_d.size(), 8);
    for (int i = 0; i < 8; i++) chk_entry("t2", i, {6'(i % 4 + 1), 10'((i / 4) * 16 + i % 4)}, 3'(i % 4));
    chk("t2_sent", sent_count, 8);

    // Backpressure: output holds X, port 1 buffers two, third push stalls
    net_ready_in = 1'b0;
    log_d.delete(); log_p.delete();
    push(0, 16'h0811);
    push(1, 16'h0C01);
    push(1, 16'h0C02);
    chk("t3_ready1", req_ready[1], 0);
    fork
      push_hold(1, 16'h0C03);
      begin
        repeat (6) begin
          cyc(1);
          chk("t3_stable", net_data_out, 16'h0811);
          chk("t3_ready_low", req_ready[1], 0);
        end
        net_ready_in = 1'b1;
      end
    join
    cyc(6);
    chk("t3_count", log_d.size(), 4);
    chk_entry("t3_0", 0, 16'h0811, 3'd0);
    chk_entry("t3_1", 1, 16'h0C01, 3'd1);
    chk_entry("t3_2", 2, 16'h0C02, 3'd1);
    chk_entry("t3_3", 3, 16'h0C03, 3'd1);

    // Illegal destination (32) dropped; dest 31 is the last legal one
    log_d.delete(); log_p.delete();
    push(2, 16'h8123);
    push(2, 16'h0401);
    chk("t4_drop", drop_count, 1);
    chk("t4_slot", net_valid_out, 0);
    push(2, 16'h7C00);
    chk("t4_valid", net_valid_out, 1);
    chk("t4_data", net_data_out, 16'h0401);
    cyc(3);
    chk("t4_count", log_d.size(), 2);
    chk_entry("t4_0", 0, 16'h0401, 3'd2);
    chk_entry("t4_1", 1, 16'h7C00, 3'd2);

    // Drop counter saturation
    for (int i = 0; i < 258; i++) push(3, 16'hFC00 | 16'(i));
    cyc(3);
    chk("t4_sat", drop_count, 8'hFF);
    chk("t4_nolog", log_d.size(), 2);

    // arb_en low: current flit drains, nothing new until re-enabled
    net_ready_in = 1'b0;
    log_d.delete(); log_p.delete();
    push(3, 16'h0C31);
    cyc(1);
    arb_en = 1'b0;
    push(3, 16'h0C32);
    push(3, 16'h0C33);
    net_ready_in = 1'b1;
    cyc(1);
    for (int i = 0; i < 4; i++) begin
      cyc(1);
      chk("t5_idle", net_valid_out, 0);
    end
    arb_en = 1'b1;
    cyc(1);
    chk("t5_valid", net_valid_out, 1);
    chk("t5_data", net_data_out, 16'h0C32);
    chk("t5_port", grant_port, 3);
    cyc(3);
    chk("t5_count", log_d.size(), 3);
    chk_entry("t5_0", 0, 16'h0C31, 3'd3);
    chk_entry("t5_1", 1, 16'h0C32, 3'd3);
    chk_entry("t5_2", 2, 16'h0C33, 3'd3);

    // Async reset with a loaded output stage and full FIFOs
    net_ready_in = 1'b0;
    push(0, 16'h1001);
    cyc(1);
    for (int k = 0; k < 2; k++) begin
      req_valid = '1;
      for (int p = 0; p < N; p++) req_data[16*p +: 16] = {6'(p + 2), 10'(k * 16 + p)};
      cyc(1);
    end
    req_valid = '0;
    chk("t6_pre_valid", net_valid_out, 1);
    chk("t6_pre_full", req_ready, 4'b0000);
    #2 ARESETn = 1'b0;
    #1;
    chk("t6_valid", net_valid_out, 0);
    chk("t6_data", net_data_out, 0);
    chk("t6_port", grant_port, 0);
    chk("t6_sent", sent_count, 0);
    chk("t6_drop", drop_count, 0);
    chk("t6_ready", req_ready, 4'b0000);
    cyc(2);
    ARESETn = 1'b1;
    net_ready_in = 1'b1;
    log_d.delete(); log_p.delete();
    push(1, 16'h0C77);
    cyc(3);
    chk("t6_count", log_d.size(), 1);
    chk_entry("t6_0", 0, 16'h0C77, 3'd1);
    chk("t6_sent_after", sent_count, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/gpu_net_arbiter.md
Name: gpu_net_arbiter

Overview:
Shares one GPU's 16-bit network-interface transmit link between N_PORTS local requesters, e.g. the NI test generator, the AXI slave completion notifier and the DMA engine. Each requester pushes flits into a small per-port FIFO. A round-robin arbiter loads one flit at a time into a registered output stage that drives the NI valid/ready link. Flits addressed to a non-existent GPU are dropped and counted.

Parameters:
N_PORTS, 4, number of requesters (2..8)
FIFO_DEPTH, 2, per-port FIFO entries (power of 2, >=2)
GPU_ID, 6, this GPU's ID (informational; loopback is allowed)
NUM_GPUS, 32, legal destination IDs are 0..NUM_GPUS-1

Ports:
ACLK  in  1  clock
ARESETn  in  1  asynchronous active-low reset
arb_en  in  1  when 0, no new grants; output stage still drains
req_valid  in  N_PORTS  per-port flit valid
req_ready  out  N_PORTS  per-port FIFO not full
req_data  in  N_PORTS*16  per-port flit; port p uses bits [16p+15:16p]; flit = {dest[5:0], payload[9:0]}
net_data_out  out  16  flit to NI
net_valid_out  out  1  output stage holds a flit
net_ready_in  in  1  NI accepts flit
grant_port  out  3  source port of the flit in the output stage
sent_count  out  16  flits accepted by NI, wraps at 2^16
drop_count  out  8  illegal-dest flits dropped, saturates at 255

Behaviour:
- Reset (async, ARESETn=0): all FIFOs empty; req_ready=all 1s once out of reset (0 during reset); net_valid_out=0; net_data_out=0; grant_port=0; rr_ptr=0; sent_count=0; drop_count=0.
- Port push: the flit is written into FIFO p when req_valid[p] && req_ready[p]. req_ready[p] = !full[p], registered FIFO state. No combinational path from req_valid to req_ready.
- Output stage is free when !net_valid_out || net_ready_in, i.e. a simultaneous drain and reload is allowed in the same cycle.
- Grant: when arb_en=1, the output stage is free and any FIFO is non-empty, select the first non-empty port searching rr_ptr, rr_ptr+1, ... mod N_PORTS.
  - Pop that FIFO the same edge.
  - If the head dest < NUM_GPUS: load net_data_out=head, net_valid_out=1, grant_port=p.
  - Otherwise: do not load, increment drop_count (saturating). net_valid_out goes to 0 if the NI just accepted.
  - In both cases rr_ptr <= (p+1) mod N_PORTS.
- Only one grant per cycle. A dropped flit consumes that cycle's grant slot.
- No grant in a cycle where the output stage is free: net_valid_out <= 0 if the NI accepted; data and grant_port hold.
- net_valid_out, once high, stays high with stable net_data_out and grant_port until net_ready_in=1.
- sent_count increments on every net_valid_out && net_ready_in; wraps 0xFFFF -> 0.
- Latency: a flit pushed at edge E into an empty FIFO, with the output stage free and no competing port at higher priority, has net_valid_out=1 after edge E+1. Sustained throughput is 1 flit/cycle when net_ready_in=1.
- Simultaneous push and pop on a full FIFO: the pop frees a slot, but req_ready was already 0 that cycle, so no push occurs. Simultaneous push and pop on a non-full FIFO are both honoured.
- Each FIFO is strictly in order; a port never overtakes itself.
- arb_en falling mid-stream: the flit already in the output stage completes normally; FIFOs keep accepting until full.
- Reset mid-transfer: the flit in the output stage is discarded and all FIFO contents are lost.

Decomposition:
- Package gpu_net_pkg holds:
  - FLIT_W=16, DEST_W=6, PAYLOAD_W=10
  - DEST_MSB=15, DEST_LSB=10
  - flit field extraction helper functions
- One sub-module, gpu_flit_fifo: synchronous FIFO of width FLIT_W and depth FIFO_DEPTH, with push/pop/full/empty/head and async reset. Instantiate it N_PORTS times.
- The round-robin pick is a function inside gpu_net_arbiter.

Test Plan:
- Single port: port 0 pushes 0x1C23 (dest 7) with net_ready_in=1 -> net_valid_out=1 with data 0x1C23 and grant_port=0 one edge after the push; sent_count=1.
- Fairness: all 4 ports hold 2 flits each, rr_ptr=0, net_ready_in=1 -> grant order 0,1,2,3,0,1,2,3 on consecutive cycles; sent_count=8.
- Backpressure: net_ready_in=0 for 10 cycles while port 1 pushes 3 flits -> net_data_out stays stable; req_ready[1]=0 after 2 further flits are buffered; the 3rd push stalls; all flits arrive in order after release.
- Illegal dest: port 2 pushes 0x8123 (dest 32) then 0x0401 (dest 1) -> drop_count=1; only 0x0401 appears on the NI; the drop takes one grant cycle.
- arb_en=0 while port 3 holds flits -> no new net_valid_out after the current flit drains; raising arb_en resumes with port 3's head.
- Async reset while net_valid_out=1 and FIFOs are full -> all outputs return to reset values immediately; after release the first new push is sent normally.
